// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous memory port between instruction
// fetch and data load/store. It runs one transaction at a time, uses
// round-robin arbitration, builds byte lanes and strobes, and extends loads.
// Optional build macro MISALIGN_TRAP_EN: when it is defined, misaligned data
// accesses finish at once with d_err. They never reach memory.
module mem_port_arbiter #(
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_funct3,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        last_data;   // 1: data was the most recent requester served
  logic        cur_data, cur_we;
  logic [2:0]  cur_f3;
  logic [1:0]  cur_lo;
  logic [3:0]  st_be;
  logic [31:0] st_wd;

  // Grant in IDLE with no delay. On a tie, the requester not served last wins.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (state == IDLE && !reset) begin
      if (if_req && d_req) begin
        if_gnt = last_data;
        d_gnt  = !last_data;
      end else begin
        if_gnt = if_req;
        d_gnt  = d_req;
      end
    end
  end

  // Store lane steering: replicate the data and pick the byte enables from the access width.
  always_comb begin
    st_be = 4'hF;
    st_wd = d_wdata;
    if (d_we) begin
      case (d_funct3)
        3'b000: begin
          st_be = 4'b0001 << d_addr[1:0];
          st_wd = {4{d_wdata[7:0]}};
        end
        3'b001: begin
          st_be = d_addr[1] ? 4'b1100 : 4'b0011;
          st_wd = {2{d_wdata[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // Select the load lane and extend it. Bit 2 of funct3 picks zero-extend.
  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] lo,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0: b = w[7:0];
      2'd1: b = w[15:8];
      2'd2: b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lo[1] ? w[31:16] : w[15:0];
    case (f3[1:0])
      2'b00:   load_ext = {{24{b[7] & ~f3[2]}}, b};
      2'b01:   load_ext = {{16{h[15] & ~f3[2]}}, h};
      default: load_ext = w;
    endcase
  endfunction

`ifdef MISALIGN_TRAP_EN
  logic d_mis;
  logic err_q;

  // Half accesses need addr[0]=0 and word accesses need addr[1:0]=0.
  // Store codes other than sb/sh count as word accesses.
  always_comb begin
    d_mis = 1'b0;
    if (d_we) begin
      if (d_funct3 == 3'b001)      d_mis = d_addr[0];
      else if (d_funct3 != 3'b000) d_mis = |d_addr[1:0];
    end else begin
      if (d_funct3[1:0] == 2'b01)      d_mis = d_addr[0];
      else if (d_funct3[1:0] != 2'b00) d_mis = |d_addr[1:0];
    end
  end
  assign d_err = err_q;
`else
  assign d_err = 1'b0;
`endif

  // Transaction sequencer. Memory strobes, responses and busy are all registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      last_data <= 1'b1;
      cur_data  <= 1'b0;
      cur_we    <= 1'b0;
      cur_f3    <= '0;
      cur_lo    <= '0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      d_rvalid  <= 1'b0;
      d_rdata   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      err_q     <= 1'b0;
`endif
    end else begin
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      case (state)
        IDLE: if (if_gnt || d_gnt) begin
          last_data <= d_gnt;
          cur_data  <= d_gnt;
          cur_we    <= d_gnt & d_we;
          cur_f3    <= d_funct3;
          cur_lo    <= d_addr[1:0];
          busy      <= 1'b1;
`ifdef MISALIGN_TRAP_EN
          if (d_gnt && d_mis) begin
            d_rvalid <= 1'b1;
            err_q    <= 1'b1;
            d_rdata  <= '0;
            state    <= RESP;
          end else
`endif
          begin
            mem_en    <= 1'b1;
            mem_we    <= d_gnt & d_we;
            mem_be    <= d_gnt ? st_be : 4'hF;
            mem_addr  <= d_gnt ? (d_addr & ~32'h3) : (if_addr & ~32'h3);
            mem_wdata <= (d_gnt && d_we) ? st_wd : '0;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          mem_en    <= 1'b0;
          mem_we    <= 1'b0;
          mem_be    <= '0;
          mem_addr  <= '0;
          mem_wdata <= '0;
          cnt       <= 4'(MEM_LATENCY - 1);
          state     <= WAIT;
        end
        // WAIT lasts MEM_LATENCY cycles. The read word is captured as the last one ends.
        WAIT: begin
          if (cnt == 4'd0) begin
            if (cur_data) begin
              d_rvalid <= 1'b1;
              d_rdata  <= cur_we ? 32'h0 : load_ext(cur_f3, cur_lo, mem_rdata);
            end else begin
              if_rvalid <= 1'b1;
              if_rdata  <= mem_rdata;
            end
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          if_rdata <= '0;
          d_rdata  <= '0;
          busy     <= 1'b0;
`ifdef MISALIGN_TRAP_EN
          err_q    <= 1'b0;
`endif
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. It uses directed spec cases, a
// round-robin run, a reset during WAIT, and randomized transactions. A
// behavioural model supplies the expected results.
module tb_mem_port_arbiter;
  localparam int L = 2;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b1;
  logic if_req = 0, d_req = 0, d_we = 0;
  logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
  logic [2:0] d_funct3 = 0;
  logic if_gnt, if_rvalid, d_gnt, d_rvalid, d_err, mem_en, mem_we, busy;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0] mem_be;
  int checks = 0, fails = 0;

  mem_port_arbiter #(.MEM_LATENCY(L)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---- reference model ----
  function automatic int acc_size(input bit we, input logic [2:0] f3);
    if (we) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [3:0] m_be(input bit isd, input bit we, input logic [2:0] f3,
                                      input logic [31:0] a);
    int sz;
    if (!isd || !we) return 4'hF;
    sz = acc_size(we, f3);
    if (sz == 1) return 4'(1 << (a % 4));
    if (sz == 2) return ((a % 4) >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] wd);
    int sz;
    sz = acc_size(1'b1, f3);
    if (sz == 1) return (wd & 32'hFF) * 32'h01010101;
    if (sz == 2) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] m_ld(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] rd);
    logic [31:0] v;
    int sz;
    sz = acc_size(1'b0, f3);
    if (sz == 1) begin
      v = (rd >> (8 * (a % 4))) & 32'hFF;
      if (f3 == 3'd0 && v >= 32'h80) v = v | 32'hFFFFFF00;
    end else if (sz == 2) begin
      v = (rd >> (16 * ((a % 4) / 2))) & 32'hFFFF;
      if (f3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF0000;
    end else v = rd;
    return v;
  endfunction

  // One full transaction from request to return-to-IDLE, with cycle-exact checks.
  task automatic do_txn(input bit isd, input bit we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd, input logic [31:0] exp_rd);
    bit trap;
    int n;
    trap = isd && TRAP && ((addr % acc_size(we, f3)) != 0);
    step();
    if (isd) begin
      d_req = 1; d_we = we; d_funct3 = f3; d_addr = addr; d_wdata = wd;
    end else begin
      if_req = 1; if_addr = addr;
    end
    mem_rdata = $urandom;
    #2;
    n = 0;
    while (!(isd ? d_gnt : if_gnt) && n < 20) begin step(); #2; n++; end
    chk("gnt", isd ? d_gnt : if_gnt, 1);
    chk("other_gnt", isd ? if_gnt : d_gnt, 0);
    step(); if_req = 0; d_req = 0; #2;                // C+1
    if (trap) begin
      chk("trap_mem_en", mem_en, 0);
      chk("trap_rvalid", d_rvalid, 1);
      chk("trap_err", d_err, 1);
      chk("trap_rdata", d_rdata, 0);
      step(); #2;                                     // C+2
      chk("trap_busy", busy, 0);
      chk("trap_rvalid_off", d_rvalid, 0);
      return;
    end
    chk("mem_en", mem_en, 1);
    chk("mem_we", mem_we, isd && we);
    chk("mem_be", mem_be, m_be(isd, we, f3, addr));
    chk("mem_addr", mem_addr, addr & ~32'h3);
    if (isd && we) chk("mem_wdata", mem_wdata, m_wd(f3, wd));
    chk("busy", busy, 1);
    for (int j = 2; j <= L + 1; j++) begin            // C+2 .. C+1+L
      step();
      mem_rdata = (j == L + 1) ? rd : $urandom;
      #2;
      chk("mem_en_off", mem_en, 0);
      chk("early_rvalid", if_rvalid | d_rvalid, 0);
    end
    step(); mem_rdata = $urandom; #2;                 // C+2+L
    chk("rvalid", isd ? d_rvalid : if_rvalid, 1);
    chk("other_rvalid", isd ? if_rvalid : d_rvalid, 0);
    chk("rdata", isd ? d_rdata : if_rdata, exp_rd);
    chk("err", d_err, 0);
    step(); #2;                                       // C+3+L
    chk("idle_busy", busy, 0);
    chk("rvalid_off", if_rvalid | d_rvalid, 0);
  endtask

  initial begin
    typedef struct { bit isd; int cyc; } gnt_t;
    gnt_t gq[$];
    repeat (3) step();
    #2;
    chk("reset_outputs", {31'd0, |{if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_err,
        mem_en, mem_we, mem_be, mem_addr, mem_wdata, busy}}, 0);

    // Both requesters are held from reset. Grants must alternate F,D,F,D, L+3 cycles apart.
    if_req = 1; if_addr = 32'h100;
    d_req = 1; d_we = 0; d_funct3 = 3'd2; d_addr = 32'h300;
    step(); reset = 0;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) step();
      #2;
      chk("dual_gnt", if_gnt & d_gnt, 0);
      if (if_gnt || d_gnt) gq.push_back('{d_gnt, c});
    end
    if_req = 0; d_req = 0;
    chk("rr_count", gq.size(), 4);
    for (int i = 0; i < gq.size() && i < 4; i++) begin
      chk("rr_who", gq[i].isd, i % 2);
      chk("rr_cycle", gq[i].cyc, i * (L + 3));
    end
    repeat (8) step();

    // Directed spec cases.
    do_txn(0, 0, 3'd0, 32'h104, 0, 32'h00A00093, 32'h00A00093);
    do_txn(1, 1, 3'd0, 32'h203, 32'hAB, 32'h0, 32'h0);
    do_txn(1, 0, 3'd0, 32'h202, 0, 32'h8280FF34, 32'hFFFFFF80);
    do_txn(1, 0, 3'd4, 32'h202, 0, 32'h8280FF34, 32'h00000080);
    do_txn(1, 0, 3'd1, 32'h202, 0, 32'h8280FF34, 32'hFFFF8280);
    do_txn(1, 0, 3'd5, 32'h202, 0, 32'h8280FF34, 32'h00008280);
    do_txn(1, 0, 3'd2, 32'h200, 0, 32'h8280FF34, 32'h8280FF34);
    do_txn(1, 0, 3'd2, 32'h206, 0, 32'h11223344, 32'h11223344);

    // Reset during WAIT drops the fetch. After that, fetch wins the first tie.
    step(); if_req = 1; if_addr = 32'h400; #2;
    chk("rst_pre_gnt", if_gnt, 1);
    step(); if_req = 0;                               // ACCESS
    step();                                           // WAIT
    reset = 1;
    step(); reset = 0; #2;
    chk("mid_reset_outputs", {31'd0, |{if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_err,
        mem_en, mem_we, mem_be, mem_addr, mem_wdata, busy}}, 0);
    for (int k = 0; k < L + 4; k++) begin
      step(); #2;
      chk("dropped_rvalid", if_rvalid | d_rvalid, 0);
    end
    step(); if_req = 1; d_req = 1; d_we = 0; d_funct3 = 3'd2; d_addr = 32'h500; #2;
    chk("post_reset_if_first", if_gnt, 1);
    chk("post_reset_d_wait", d_gnt, 0);
    step(); if_req = 0; d_req = 0;
    repeat (L + 4) step();

    // Randomized transactions against the model.
    for (int t = 0; t < 40; t++) begin
      bit isd, we;
      logic [2:0] f3;
      logic [31:0] a, wd, rd, e;
      isd = 1'($urandom_range(0, 1));
      we  = isd ? 1'($urandom_range(0, 1)) : 1'b0;
      f3  = 3'($urandom_range(0, 7));
      a   = $urandom; wd = $urandom; rd = $urandom;
      e   = !isd ? rd : (we ? 32'h0 : m_ld(f3, a, rd));
      do_txn(isd, we, f3, a, wd, rd, e);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
